leaf_index_arbiter: RTL and testbench

- Sits directly downstream of the KD-tree internal-node traversal stage.
- Captures the two per-cycle leaf-index results (stream one, stream two) together with their receiver strobes.
- Tags each result with a stream bit and a per-stream query sequence number, then buffers it in a small FIFO.
- Serialises results into a single valid/ready leaf-memory request stream for the leaf-search stage.

---
 rtl/leaf_index_arbiter.sv | 129 ++++++++++++
 tb/tb_leaf_index_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/leaf_index_arbiter.sv
// Leaf-index arbiter: tags two leaf-index streams and serialises them through a FIFO.
// Optional statistics counters are enabled with the LEAF_ARB_STATS_EN macro.
module leaf_index_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int QID_WIDTH     = 10,
    parameter int DEPTH         = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     receiver_en,
    input  logic [ADDRESS_WIDTH-1:0] leaf_index,
    input  logic                     receiver_two_en,
    input  logic [ADDRESS_WIDTH-1:0] leaf_index_two,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_leaf_index,
    output logic                     out_stream,
    output logic [QID_WIDTH-1:0]     out_qid,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow
`ifdef LEAF_ARB_STATS_EN
    ,
    output logic [15:0]              stat_issued,
    output logic [15:0]              stat_dropped,
    output logic [15:0]              stat_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + QID_WIDTH + ADDRESS_WIDTH;

    logic [EW-1:0]        mem [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        wr_ptr_two;
    logic [QID_WIDTH-1:0] qid_one;
    logic [QID_WIDTH-1:0] qid_two;
    logic [CW-1:0]        free;
    logic                 pop;
    logic                 admit_one;
    logic                 admit_two;
    logic                 drop_one;
    logic                 drop_two;
    logic [EW-1:0]        head;

    assign out_valid = (fill_level != '0);
    assign pop       = out_valid && out_ready;
    assign free      = CW'(DEPTH) - fill_level + CW'(pop);

    // Stream one claims the first free slot; stream two takes what remains.
    always_comb begin
        admit_one = receiver_en && (free != '0);
        admit_two = 1'b0;
        if (receiver_two_en) begin
            if (admit_one) admit_two = (free >= CW'(2));
            else           admit_two = (free != '0);
        end
        drop_one = receiver_en && !admit_one;
        drop_two = receiver_two_en && !admit_two;
    end

    assign wr_ptr_two = wr_ptr + PW'(admit_one);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            qid_one    <= '0;
            qid_two    <= '0;
            overflow   <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            qid_one    <= '0;
            qid_two    <= '0;
            overflow   <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr + PW'(pop);
            wr_ptr     <= wr_ptr + PW'(admit_one) + PW'(admit_two);
            fill_level <= fill_level + CW'(admit_one) + CW'(admit_two)
                          - CW'(pop);
            qid_one    <= qid_one + QID_WIDTH'(receiver_en);
            qid_two    <= qid_two + QID_WIDTH'(receiver_two_en);
            if (drop_one || drop_two) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (admit_one) mem[wr_ptr]     <= {1'b0, qid_one, leaf_index};
            if (admit_two) mem[wr_ptr_two] <= {1'b1, qid_two, leaf_index_two};
        end
    end

    assign head = mem[rd_ptr];
    assign {out_stream, out_qid, out_leaf_index} = out_valid ? head : '0;

`ifdef LEAF_ARB_STATS_EN
    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [1:0]  b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_dropped <= '0;
            stat_stall   <= '0;
        end else if (flush) begin
            stat_issued  <= '0;
            stat_dropped <= '0;
            stat_stall   <= '0;
        end else begin
            stat_issued  <= sat_add(stat_issued, {1'b0, pop});
            stat_dropped <= sat_add(stat_dropped,
                                    {1'b0, drop_one} + {1'b0, drop_two});
            stat_stall   <= sat_add(stat_stall,
                                    {1'b0, out_valid && !out_ready});
        end
    end
`endif

endmodule

// File: tb/tb_leaf_index_arbiter.sv
// Directed bench for leaf_index_arbiter with a queue-based scoreboard.
module tb_leaf_index_arbiter;

    localparam int AW = 8;
    localparam int QW = 10;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          e1 = 1'b0;
    logic          e2 = 1'b0;
    logic          rdy = 1'b0;
    logic [AW-1:0] l1 = '0;
    logic [AW-1:0] l2 = '0;
    logic          out_valid;
    logic [AW-1:0] out_leaf_index;
    logic          out_stream;
    logic [QW-1:0] out_qid;
    logic [3:0]    fill_level;
    logic          overflow;

    leaf_index_arbiter #(.ADDRESS_WIDTH(AW), .QID_WIDTH(QW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .receiver_en(e1), .leaf_index(l1),
        .receiver_two_en(e2), .leaf_index_two(l2),
        .out_valid(out_valid), .out_ready(rdy),
        .out_leaf_index(out_leaf_index), .out_stream(out_stream),
        .out_qid(out_qid), .fill_level(fill_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [18:0] q[$];
    logic [QW-1:0] m1 = '0;
    logic [QW-1:0] m2 = '0;
    logic movf = 1'b0;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m1 = '0;
        m2 = '0;
        movf = 1'b0;
    endtask

    // Drive one cycle, check the pre-edge outputs, then advance the model.
    task automatic step(input logic a1, input logic [AW-1:0] x1,
                        input logic a2, input logic [AW-1:0] x2,
                        input logic r, input logic f);
        logic [18:0] h;
        @(negedge clk);
        e1 = a1; l1 = x1; e2 = a2; l2 = x2; rdy = r; flush = f;
        #1;
        h = (q.size() != 0) ? q[0] : 19'd0;
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("fill", 32'(fill_level), 32'(q.size()));
        chk("ovf", 32'(overflow), 32'(movf));
        chk("head", 32'({out_stream, out_qid, out_leaf_index}), 32'(h));
        if (f) begin
            model_clear();
        end else begin
            if (q.size() != 0 && r) void'(q.pop_front());
            if (a1) begin
                if (q.size() < D) q.push_back({1'b0, m1, x1});
                else movf = 1'b1;
                m1++;
            end
            if (a2) begin
                if (q.size() < D) q.push_back({1'b1, m2, x2});
                else movf = 1'b1;
                m2++;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_idx", 32'(out_leaf_index), 0);
        rst = 1'b0;

        // single push
        step(1, 8'h2A, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("sp_idx", 32'(out_leaf_index), 32'h2A);
        chk("sp_qid", 32'(out_qid), 0);
        chk("sp_fill", 32'(fill_level), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("sp_empty", 32'(out_valid), 0);

        // simultaneous push, stream one first
        step(0, 0, 0, 0, 0, 1);
        step(1, 8'h05, 1, 8'h3F, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("dual_fill2", 32'(fill_level), 2);
        step(0, 0, 0, 0, 1, 0);
        chk("dual_second", 32'({out_stream, out_qid, out_leaf_index}),
            32'({1'b1, 10'd0, 8'h3F}));
        step(0, 0, 0, 0, 1, 0);

        // full FIFO with same-cycle pop: stream two dropped
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < D; i++) step(1, 8'(8'h10 + i), 0, 0, 0, 0);
        step(1, 8'hAA, 1, 8'hBB, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("full_fill", 32'(fill_level), 8);
        chk("full_ovf", 32'(overflow), 1);
        for (int i = 0; i < D; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 8'hCC, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("gap_qid", 32'(out_qid), 1);
        chk("ovf_sticky", 32'(overflow), 1);

        // pointer wrap with interleaved pops
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            step(1, 8'(8'h40 + i), 0, 0, (i % 3) != 0, 0);
        while (q.size() != 0) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // qid counter wrap on stream two
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 1030; i++) step(0, 0, 1, 8'(i), 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("qwrap_qid", 32'(out_qid), 5);
        step(0, 0, 0, 0, 1, 0);

        // flush with entries queued and strobes high
        step(1, 8'h01, 1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0, 0, 0);
        step(1, 8'h77, 1, 8'h78, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("fl_fill", 32'(fill_level), 0);
        chk("fl_valid", 32'(out_valid), 0);
        step(0, 0, 1, 8'h99, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("fl_qid", 32'(out_qid), 0);

        // asynchronous reset mid-operation
        step(1, 8'h11, 1, 8'h12, 0, 0);
        step(1, 8'h13, 0, 0, 0, 0);
        @(negedge clk);
        e1 = 0; e2 = 0; rdy = 0; flush = 0;
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_fill", 32'(fill_level), 0);
        rst = 1'b0;
        model_clear();
        step(1, 8'h21, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("arst_qid", 32'(out_qid), 0);
        step(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
